// File: rtl/pid_sample_sequencer.sv
// Sample-tick sequencer for a PID controller handshake, plus a period-synchronous servo PWM generator.
// Optional build macro SEQ_TIMEOUT_EN bounds the wait for the controller's done.
module pid_sample_sequencer #(
  parameter int WIDTH       = 12,
  parameter int DIV         = 50000,
  parameter int PWM_PRESC   = 1,
  parameter int DUTY_MIN    = 1024,
  parameter int DUTY_MAX    = 3072,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] sensor_i,
  input  logic             sensor_valid_i,
  output logic [WIDTH-1:0] ctrl_y_k_o,
  output logic             ctrl_start_o,
  input  logic             ctrl_done_i,
  input  logic [WIDTH-1:0] ctrl_servo_i,
  output logic [WIDTH-1:0] duty_o,
  output logic             pwm_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             timeout_o
);

  localparam int TW = $clog2(DIV);
  localparam int PW = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
  localparam logic [WIDTH-1:0]        NEUTRAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0]   DMIN_S  = (WIDTH+1)'(DUTY_MIN);
  localparam logic signed [WIDTH:0]   DMAX_S  = (WIDTH+1)'(DUTY_MAX);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, UPDATE} state_t;

  // ---------------- sample tick ----------------
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  assign tick = en_i && (tick_cnt_q == TW'(DIV - 1));

  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (!en_i || tick) tick_cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  // ---------------- sensor latch ----------------
  logic [WIDTH-1:0] sens_q;

  always_ff @(posedge clk_i) begin
    if (reset)               sens_q <= '0;
    else if (sensor_valid_i) sens_q <= sensor_i;
  end

  // ---------------- duty conversion ----------------
  // Offset-binary in WIDTH+1 signed bits cannot overflow for any WIDTH-bit servo value.
  logic signed [WIDTH:0] d_raw;
  logic [WIDTH-1:0]      duty_calc;

  assign d_raw = $signed({ctrl_servo_i[WIDTH-1], ctrl_servo_i}) + $signed({2'b01, {(WIDTH-1){1'b0}}});

  always_comb begin
    duty_calc = WIDTH'(d_raw);
    if (d_raw < DMIN_S)      duty_calc = WIDTH'(DUTY_MIN);
    else if (d_raw > DMAX_S) duty_calc = WIDTH'(DUTY_MAX);
  end

  // ---------------- handshake FSM ----------------
  state_t           state_q;
  logic [WIDTH-1:0] y_k_q;
  logic [WIDTH-1:0] shadow_q;
  logic             start_q, busy_q, overrun_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt_q;
  logic          timeout_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q    <= IDLE;
      y_k_q      <= '0;
      shadow_q   <= NEUTRAL;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      if (tick && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (tick) begin
          state_q <= START;
          y_k_q   <= sens_q;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        START: begin
          state_q <= WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        WAIT_DONE: begin
          if (ctrl_done_i) state_q <= UPDATE;
`ifdef SEQ_TIMEOUT_EN
          // Done on the final permitted cycle wins over the timeout.
          else if (wait_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
`endif
        end
        UPDATE: begin
          shadow_q <= duty_calc;
          state_q  <= IDLE;
          busy_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_y_k_o   = y_k_q;
  assign ctrl_start_o = start_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;
`ifdef SEQ_TIMEOUT_EN
  assign timeout_o    = timeout_q;
`else
  assign timeout_o    = 1'b0;
`endif

  // ---------------- PWM ----------------
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             step, wrap;

  assign step = (presc_q == PW'(PWM_PRESC - 1));
  assign wrap = step && (&pwm_cnt_q);

  always_comb begin
    presc_d   = step ? '0 : presc_q + PW'(1);
    pwm_cnt_d = step ? pwm_cnt_q + WIDTH'(1) : pwm_cnt_q;
    // Active duty only changes at the period boundary, so no period is ever truncated.
    duty_d    = wrap ? shadow_q : duty_q;
    pwm_d     = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      duty_q    <= NEUTRAL;
      pwm_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
    end
  end

  assign duty_o = duty_q;
  assign pwm_o  = pwm_q;

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Directed bench for pid_sample_sequencer: controller model plus scoreboard queues for y_k and duty.
module tb_pid_sample_sequencer;
  localparam int W = 12;
  localparam int DIVP = 20;
  localparam int PER = 4096;

  logic          clk_i = 1'b0, reset = 1'b1, en_i = 1'b0, sensor_valid_i = 1'b0, ctrl_done_i = 1'b0;
  logic [W-1:0]  sensor_i = '0, ctrl_servo_i = '0;
  logic [W-1:0]  ctrl_y_k_o, duty_o;
  logic          ctrl_start_o, pwm_o, busy_o, overrun_o, timeout_o;

  pid_sample_sequencer #(.WIDTH(W), .DIV(DIVP), .PWM_PRESC(1), .DUTY_MIN(1024), .DUTY_MAX(3072),
                         .TIMEOUT_CYC(32)) dut (
    .clk_i(clk_i), .reset(reset), .en_i(en_i), .sensor_i(sensor_i), .sensor_valid_i(sensor_valid_i),
    .ctrl_y_k_o(ctrl_y_k_o), .ctrl_start_o(ctrl_start_o), .ctrl_done_i(ctrl_done_i),
    .ctrl_servo_i(ctrl_servo_i), .duty_o(duty_o), .pwm_o(pwm_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int R = 0, cur_duty = 2048;
  int exp_duty_q[$];
  logic [W-1:0] exp_yk_q[$];

  // Controller model: answers model_delay cycles after it sees start (negative = never).
  int                  model_delay = 10, m_cnt = -1;
  logic signed [W-1:0] model_servo = '0, m_servo_l = '0;
  logic                done_hold = 1'b0;
  always @(negedge clk_i) begin
    logic pulse;
    pulse = 1'b0;
    if (ctrl_start_o) begin
      m_cnt = model_delay;
      m_servo_l = model_servo;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) pulse = 1'b1;
    end
    ctrl_done_i  = pulse | done_hold;
    ctrl_servo_i = m_servo_l;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int exp_duty(input int s);
    int d;
    d = s + 2048;
    if (d < 1024) d = 1024;
    if (d > 3072) d = 3072;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  task automatic wait_start(input string tag, output int t);
    int n;
    n = 0;
    while (!ctrl_start_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_start_seen"}, ctrl_start_o, 1);
    t = cyc;
    chk({tag, "_y_k"}, ctrl_y_k_o, exp_yk_q.pop_front());
    @(negedge clk_i);
    chk({tag, "_start_single"}, ctrl_start_o, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic wrap_check(input string tag);
    int n;
    n = 0;
    while (((cyc - R) % PER) != PER - 1 && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_wrap_reached"}, (cyc - R) % PER, PER - 1);
    chk({tag, "_duty_before_wrap"}, duty_o, cur_duty);
    @(negedge clk_i);
    cur_duty = exp_duty_q.pop_front();
    chk({tag, "_duty_at_wrap"}, duty_o, cur_duty);
  endtask

  task automatic load_sensor(input logic [W-1:0] v);
    sensor_i = v;
    sensor_valid_i = 1'b1;
    @(negedge clk_i);
    sensor_valid_i = 1'b0;
    sensor_i = ~v;
    exp_yk_q.push_back(v);
  endtask

  task automatic handshake(input string tag, input logic [W-1:0] sens, input int servo);
    int e, s;
    load_sensor(sens);
    model_servo = W'(servo);
    model_delay = 10;
    e = cyc;
    en_i = 1'b1;
    wait_start(tag, s);
    en_i = 1'b0;
    chk({tag, "_start_latency"}, s, e + DIVP);
    wait_idle(tag);
    exp_duty_q.push_back(exp_duty(servo));
    wrap_check(tag);
  endtask

  initial begin
    int s1, s2, s;

    // 1. reset values and first PWM period
    reset = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_y_k", ctrl_y_k_o, 0);
    chk("rst_start", ctrl_start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_pwm", pwm_o, 0);
    chk("rst_duty", duty_o, 2048);
    reset = 1'b0;
    R = cyc;
    wait_until(R + 1);    chk("pwm_first", pwm_o, 1);
    wait_until(R + 2048); chk("pwm_last_high", pwm_o, 1);
    wait_until(R + 2049); chk("pwm_first_low", pwm_o, 0);

    // 2. basic handshake, duty lands at the wrap
    handshake("t2", 12'h155, 100);
    chk("t2_no_overrun", overrun_o, 0);

    // 3. clamp boundaries and neutral
    handshake("t3_min", 12'h2AA, -2048);
    handshake("t3_max", 12'h0F1, 2047);
    handshake("t3_zero", 12'h7FF, 0);

    // 4. slow controller -> overrun; next handshake still completes, last update wins
    load_sensor(12'h0F0);
    model_servo = 12'sd300;
    model_delay = 25;
    en_i = 1'b1;
    wait_start("t4a", s1);
    model_servo = 12'sd500;
    model_delay = 10;
    exp_yk_q.push_back(12'h0F0);
    wait_until(s1 + 19); chk("t4_overrun_pre", overrun_o, 0);
    wait_until(s1 + 20); chk("t4_overrun_set", overrun_o, 1);
    wait_start("t4b", s2);
    en_i = 1'b0;
    chk("t4_second_start", s2, s1 + 2 * DIVP);
    wait_idle("t4");
    exp_duty_q.push_back(exp_duty(500));
    wrap_check("t4");
    chk("t4_overrun_sticky", overrun_o, 1);

    // 5. controller never answers
    load_sensor(12'h333);
    model_delay = -1;
    en_i = 1'b1;
    wait_start("t5", s);
    en_i = 1'b0;
    wait_until(s + 32);
    chk("t5_timeout_pre", timeout_o, 0);
    chk("t5_busy_pre", busy_o, 1);
    wait_until(s + 33);
`ifdef SEQ_TIMEOUT_EN
    chk("t5_timeout", timeout_o, 1);
    wait_until(s + 34);
    chk("t5_busy_after", busy_o, 0);
`else
    chk("t5_timeout", timeout_o, 0);
    wait_until(s + 34);
    chk("t5_busy_after", busy_o, 1);
`endif
    exp_duty_q.push_back(cur_duty);
    wrap_check("t5");

    // 6. reset during WAIT_DONE with done held high afterwards
`ifdef SEQ_TIMEOUT_EN
    load_sensor(12'h444);
    en_i = 1'b1;
    wait_start("t6", s);
    en_i = 1'b0;
`endif
    repeat (5) @(negedge clk_i);
    chk("t6_busy_waiting", busy_o, 1);
    done_hold = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_start", ctrl_start_o, 0);
    chk("t6_rst_overrun", overrun_o, 0);
    chk("t6_rst_timeout", timeout_o, 0);
    chk("t6_rst_duty", duty_o, 2048);
    cur_duty = 2048;
    reset = 1'b0;
    R = cyc;
    wait_until(R + 2);  chk("t6_idle_a", busy_o, 0); chk("t6_no_start", ctrl_start_o, 0);
    wait_until(R + 10); chk("t6_idle_b", busy_o, 0);
    done_hold = 1'b0;
    exp_duty_q.push_back(2048);
    wrap_check("t6_nochange");
    handshake("t6_after", 12'h0AB, -500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
